// File: rtl/hdu_pkg.sv
// Hazard detection unit types: cause encoding reported alongside stall/flush.
package hdu_pkg;
    typedef enum logic [2:0] {
        NONE     = 3'd0,
        BRANCH   = 3'd1,
        LOAD_USE = 3'd2,
        RAW_LONG = 3'd3,
        WAW_LONG = 3'd4,
        FULL     = 3'd5
    } hazard_cause_t;
endpackage

// File: rtl/rv32i_defs.sv
// Core-wide RV32I architectural constants shared by pipeline blocks.
package rv32i_defs;
    localparam int RF_ADDR_WIDTH = 5;
endpackage

// File: rtl/hdu_scoreboard.sv
// Busy bitmap and outstanding-count tracker for multi-cycle register writes.
module hdu_scoreboard
    import hdu_pkg::*;
#(
    parameter  int ADDR_W      = 5,
    parameter  int MAX_PENDING = 4,
    localparam int NREGS       = 2 ** ADDR_W,
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_clr_addr,
    output logic [NREGS-1:0]  o_busy_eff,
    output logic              o_valid_clr,
    output logic [CNT_W-1:0]  o_pending_count
);
    logic [NREGS-1:0] r_busy;
    logic [CNT_W-1:0] r_count;
    logic [NREGS-1:0] w_wb_mask;
    logic [NREGS-1:0] w_after_clr;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_busy_next;
    logic             w_set_new;

    // Any writeback hides its register from this cycle's hazard checks.
    assign w_wb_mask   = i_clr ? (NREGS'(1) << i_clr_addr) : '0;
    assign o_busy_eff  = r_busy & ~w_wb_mask;
    assign o_valid_clr = i_clr && (i_clr_addr != '0) && r_busy[i_clr_addr];

    // Clear applies before set so a same-cycle retire/reissue of X stays busy.
    assign w_after_clr = r_busy & ~w_wb_mask;
    assign w_set_new   = i_set && (i_set_addr != '0) && !w_after_clr[i_set_addr];
    assign w_set_mask  = w_set_new ? (NREGS'(1) << i_set_addr) : '0;
    assign w_busy_next = w_after_clr | w_set_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy <= {w_busy_next[NREGS-1:1], 1'b0};
            if (w_set_new && !o_valid_clr)
                r_count <= r_count + CNT_W'(1);
            else if (!w_set_new && o_valid_clr)
                r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_pending_count = r_count;
endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detection: load-use, long-op RAW/WAW, scoreboard-full and branch flush.
module hazard_scoreboard
    import hdu_pkg::*;
#(
    parameter  int RF_ADDR_WIDTH = rv32i_defs::RF_ADDR_WIDTH,
    parameter  int MAX_PENDING   = 4,
    localparam int CNT_W         = $clog2(MAX_PENDING + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     idValid,
    input  logic [RF_ADDR_WIDTH-1:0] idRs1,
    input  logic [RF_ADDR_WIDTH-1:0] idRs2,
    input  logic [RF_ADDR_WIDTH-1:0] idRd,
    input  logic                     idUsesRs1,
    input  logic                     idUsesRs2,
    input  logic                     idRegWrite,
    input  logic                     idMemWrite,
    input  logic                     idLongOp,
    input  logic [RF_ADDR_WIDTH-1:0] exRd,
    input  logic                     exMemRead,
    input  logic                     wbValid,
    input  logic [RF_ADDR_WIDTH-1:0] wbRd,
    input  logic                     branchOrJump,
    output logic                     stall_n,
    output logic                     flushIdEx,
    output logic                     flushIfIdExMem,
    output logic [2:0]               hazardCause,
    output logic [CNT_W-1:0]         pendingCount
);
    localparam int NREGS = 2 ** RF_ADDR_WIDTH;

    logic [NREGS-1:0] w_busy_eff;
    logic             w_valid_clr;
    logic [CNT_W-1:0] w_pending;
    logic             w_load_use;
    logic             w_raw_long;
    logic             w_waw_long;
    logic             w_long_wr;
    logic             w_full;
    logic             w_issue;
    hazard_cause_t    w_cause;

    hdu_scoreboard #(
        .ADDR_W      (RF_ADDR_WIDTH),
        .MAX_PENDING (MAX_PENDING)
    ) u_scoreboard (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_set           (w_issue),
        .i_set_addr      (idRd),
        .i_clr           (wbValid),
        .i_clr_addr      (wbRd),
        .o_busy_eff      (w_busy_eff),
        .o_valid_clr     (w_valid_clr),
        .o_pending_count (w_pending)
    );

    // Store data (rs2) is forwarded late from MEM, so only rs1 forces a load-use stall for stores.
    assign w_load_use = idValid && exMemRead && (exRd != '0) &&
                        ((idUsesRs1 && (exRd == idRs1)) ||
                         (idUsesRs2 && (exRd == idRs2) && !idMemWrite));

    assign w_raw_long = idValid &&
                        ((idUsesRs1 && (idRs1 != '0) && w_busy_eff[idRs1]) ||
                         (idUsesRs2 && (idRs2 != '0) && w_busy_eff[idRs2]));

    assign w_waw_long = idValid && idRegWrite && (idRd != '0) && w_busy_eff[idRd];

    assign w_long_wr  = idValid && idLongOp && idRegWrite && (idRd != '0);

    // A retiring entry frees its slot this cycle; a writeback to an idle register frees nothing.
    assign w_full     = w_long_wr && (w_pending == CNT_W'(MAX_PENDING)) && !w_valid_clr;

    always_comb begin
        w_cause = NONE;
        if (branchOrJump)    w_cause = BRANCH;
        else if (w_load_use) w_cause = LOAD_USE;
        else if (w_raw_long) w_cause = RAW_LONG;
        else if (w_waw_long) w_cause = WAW_LONG;
        else if (w_full)     w_cause = FULL;
    end

    always_comb begin
        stall_n        = 1'b1;
        flushIdEx      = 1'b0;
        flushIfIdExMem = 1'b0;
        case (w_cause)
            NONE: ;
            BRANCH: begin
                flushIdEx      = 1'b1;
                flushIfIdExMem = 1'b1;
            end
            default: begin
                stall_n   = 1'b0;
                flushIdEx = 1'b1;
            end
        endcase
    end

    assign w_issue      = w_long_wr && (w_cause == NONE);
    assign hazardCause  = w_cause;
    assign pendingCount = w_pending;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against a pending-list model.
module tb_hazard_scoreboard;
    localparam int AW   = 5;
    localparam int MAXP = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          idValid, idUsesRs1, idUsesRs2, idRegWrite, idMemWrite, idLongOp;
    logic [AW-1:0] idRs1, idRs2, idRd, exRd, wbRd;
    logic          exMemRead, wbValid, branchOrJump;
    logic          stall_n, flushIdEx, flushIfIdExMem;
    logic [2:0]    hazardCause;
    logic [1:0]    pendingCount;

    int n_checks = 0;
    int n_pass   = 0;
    int pend_q[$];

    hazard_scoreboard #(.RF_ADDR_WIDTH(AW), .MAX_PENDING(MAXP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .idValid        (idValid),
        .idRs1          (idRs1),
        .idRs2          (idRs2),
        .idRd           (idRd),
        .idUsesRs1      (idUsesRs1),
        .idUsesRs2      (idUsesRs2),
        .idRegWrite     (idRegWrite),
        .idMemWrite     (idMemWrite),
        .idLongOp       (idLongOp),
        .exRd           (exRd),
        .exMemRead      (exMemRead),
        .wbValid        (wbValid),
        .wbRd           (wbRd),
        .branchOrJump   (branchOrJump),
        .stall_n        (stall_n),
        .flushIdEx      (flushIdEx),
        .flushIfIdExMem (flushIfIdExMem),
        .hazardCause    (hazardCause),
        .pendingCount   (pendingCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit pend_has(int r);
        foreach (pend_q[i]) if (pend_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Register still appears busy unless this cycle's writeback targets it.
    function automatic bit busy_seen(int r);
        return (r != 0) && pend_has(r) && !(wbValid && (int'(wbRd) == r));
    endfunction

    task automatic idle();
        idValid = 0; idUsesRs1 = 0; idUsesRs2 = 0; idRegWrite = 0; idMemWrite = 0; idLongOp = 0;
        idRs1 = '0; idRs2 = '0; idRd = '0; exRd = '0; exMemRead = 0;
        wbValid = 0; wbRd = '0; branchOrJump = 0;
    endtask

    task automatic id_instr(input int rs1, input int rs2, input int rd, input bit u1, input bit u2,
                            input bit wr, input bit st, input bit lng);
        idValid = 1; idRs1 = AW'(rs1); idRs2 = AW'(rs2); idRd = AW'(rd);
        idUsesRs1 = u1; idUsesRs2 = u2; idRegWrite = wr; idMemWrite = st; idLongOp = lng;
    endtask

    // Inputs are applied just after a rising edge; outputs are sampled 2ns later, then the model advances on the edge.
    task automatic step(input int want_cause = -1);
        int   cause;
        bit   wb_hit, long_wr;
        logic [2:0] flags;
        int   idx;
        #2;
        wb_hit  = wbValid && (wbRd != 0) && pend_has(int'(wbRd));
        long_wr = idValid && idLongOp && idRegWrite && (idRd != 0);
        if (branchOrJump) cause = 1;
        else if (idValid && exMemRead && exRd != 0 &&
                 ((idUsesRs1 && exRd == idRs1) || (idUsesRs2 && exRd == idRs2 && !idMemWrite))) cause = 2;
        else if (idValid && ((idUsesRs1 && busy_seen(int'(idRs1))) || (idUsesRs2 && busy_seen(int'(idRs2))))) cause = 3;
        else if (idValid && idRegWrite && busy_seen(int'(idRd))) cause = 4;
        else if (long_wr && pend_q.size() == MAXP && !wb_hit) cause = 5;
        else cause = 0;
        flags = (cause == 0) ? 3'b100 : (cause == 1) ? 3'b111 : 3'b010;
        check("outputs", 32'({stall_n, flushIdEx, flushIfIdExMem, hazardCause}), 32'({flags, 3'(cause)}));
        check("pending", 32'(pendingCount), 32'(pend_q.size()));
        if (want_cause >= 0) check("directed_cause", 32'(hazardCause), 32'(want_cause));
        @(posedge clk);
        if (wb_hit) begin
            idx = -1;
            foreach (pend_q[i]) if (pend_q[i] == int'(wbRd)) idx = i;
            if (idx >= 0) pend_q.delete(idx);
        end
        if (long_wr && cause == 0) pend_q.push_back(int'(idRd));
        #1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        @(posedge clk); #1;
        step(0);
        step(0);
        rst_n = 1;
        step(0);

        // Load-use on rs1, then store whose data register is the load target.
        exMemRead = 1; exRd = 5;
        id_instr(5, 2, 6, 1, 1, 1, 0, 0);
        step(2);
        id_instr(1, 5, 0, 1, 1, 0, 1, 0);
        step(0);

        // mul x7 then consumer stalls until writeback bypass.
        idle();
        id_instr(1, 2, 7, 1, 1, 1, 0, 1);
        step(0);
        id_instr(7, 3, 8, 1, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(3);
        wbValid = 1; wbRd = 7;
        step(0);
        idle();
        step(0);

        // Fill the scoreboard, hit FULL, then retire-and-issue in the same cycle.
        for (int r = 1; r <= MAXP; r++) begin
            id_instr(0, 0, r, 0, 0, 1, 0, 1);
            step(0);
        end
        id_instr(0, 0, 4, 0, 0, 1, 0, 1);
        step(5);
        wbValid = 1; wbRd = 1;
        step(0);
        idle();
        step(0);

        // Branch overrides a RAW hazard and suppresses issue.
        id_instr(4, 0, 10, 1, 0, 1, 0, 1);
        branchOrJump = 1;
        step(1);
        idle();
        step(0);

        // Asynchronous reset with three entries pending.
        #2 rst_n = 0;
        #1 check("async_reset_count", 32'(pendingCount), 32'd0);
        pend_q.delete();
        @(posedge clk); #1;
        rst_n = 1;
        wbValid = 1; wbRd = 4;
        step(0);
        idle();
        step(0);

        // Long op to x0 is not tracked; WAW against busy x9.
        id_instr(0, 0, 0, 0, 0, 1, 0, 1);
        step(0);
        idle();
        step(0);
        id_instr(0, 0, 9, 0, 0, 1, 0, 1);
        step(0);
        id_instr(0, 0, 9, 0, 0, 1, 0, 0);
        step(4);

        for (int c = 0; c < 400; c++) begin
            idValid      = ($urandom_range(0, 9) != 0);
            idRs1        = AW'($urandom_range(0, 7));
            idRs2        = AW'($urandom_range(0, 7));
            idRd         = AW'($urandom_range(0, 7));
            idUsesRs1    = 1'($urandom_range(0, 1));
            idUsesRs2    = 1'($urandom_range(0, 1));
            idMemWrite   = ($urandom_range(0, 5) == 0);
            idRegWrite   = !idMemWrite && ($urandom_range(0, 3) != 0);
            idLongOp     = ($urandom_range(0, 2) == 0);
            exMemRead    = ($urandom_range(0, 3) == 0);
            exRd         = AW'($urandom_range(0, 7));
            branchOrJump = ($urandom_range(0, 11) == 0);
            wbValid      = ($urandom_range(0, 2) == 0);
            if (wbValid && pend_q.size() > 0 && $urandom_range(0, 3) != 0)
                wbRd = AW'(pend_q[$urandom_range(0, 32'(pend_q.size() - 1))]);
            else
                wbRd = AW'($urandom_range(0, 7));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter RF_ADDR_WIDTH, default 5, register-file address width.
REQ-002 SHALL have parameter MAX_PENDING, default 4, maximum outstanding long-latency writes (1..2**RF_ADDR_WIDTH-1).
REQ-003 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-004 SHALL have ports: idValid in 1, ID-stage instruction valid; idRs1, idRs2, idRd in RF_ADDR_WIDTH, ID source/destination addresses.
REQ-005 SHALL have ports: idUsesRs1, idUsesRs2, idRegWrite, idMemWrite, idLongOp in 1, ID operand use, writes rd, is store, is multi-cycle (mul/div/long load).
REQ-006 SHALL have ports: exRd in RF_ADDR_WIDTH, exMemRead in 1, EX-stage single-cycle load destination.
REQ-007 SHALL have ports: wbValid in 1, wbRd in RF_ADDR_WIDTH, long-op completion writing wbRd.
REQ-008 SHALL have port: branchOrJump in 1, taken branch/jump resolved this cycle.
REQ-009 SHALL have outputs: stall_n 1 (active-low, to PC and IF/ID enable); flushIdEx 1 (bubble/flush into ID/EX); flushIfIdExMem 1 (flush IF/ID and EX/MEM).
REQ-010 SHALL have outputs: hazardCause 3, encoded hazard_cause_t; pendingCount $clog2(MAX_PENDING+1), outstanding long ops.

Function
REQ-011 SHALL hold busy[2**RF_ADDR_WIDTH] bitmap and pendingCount register; busy[0] SHALL be constant 0.
REQ-012 SHALL compute busyEff = busy with bit wbRd cleared when wbValid (same-cycle WB bypass).
REQ-013 SHALL evaluate priority, highest first: BRANCH, LOAD_USE, RAW_LONG, WAW_LONG, FULL, NONE.
REQ-014 BRANCH (branchOrJump=1): stall_n=1, flushIdEx=1, flushIfIdExMem=1, no scoreboard set.
REQ-015 LOAD_USE: idValid, exMemRead, exRd!=0, and (idUsesRs1 and exRd==idRs1, or idUsesRs2 and exRd==idRs2 and not idMemWrite) -> stall_n=0, flushIdEx=1, flushIfIdExMem=0.
REQ-016 RAW_LONG: idValid and a used source with nonzero address has busyEff set -> same outputs as LOAD_USE; store rs2 is NOT exempt.
REQ-017 WAW_LONG: idValid, idRegWrite, idRd!=0, busyEff[idRd] -> same outputs as LOAD_USE.
REQ-018 FULL: idValid, idLongOp, idRegWrite, idRd!=0, pendingCount==MAX_PENDING and not wbValid -> same outputs as LOAD_USE.
REQ-019 NONE: stall_n=1, flushIdEx=0, flushIfIdExMem=0.
REQ-020 Issue = idValid and idLongOp and idRegWrite and idRd!=0 and cause NONE; on issue busy[idRd] SHALL be set at next clk edge.
REQ-021 wbValid with wbRd!=0 and busy[wbRd]=1 SHALL clear busy[wbRd] next edge; wbValid on non-busy register SHALL be ignored (no count change).
REQ-022 pendingCount next = pendingCount + issue - validClear; simultaneous issue and clear SHALL leave it unchanged; SHALL never exceed MAX_PENDING or underflow.
REQ-023 Same-cycle clear of X and issue to X SHALL leave busy[X]=1, count unchanged.
REQ-024 Outputs SHALL be combinational from inputs and registered state (zero-cycle decision); scoreboard update latency one cycle.
REQ-025 branchOrJump SHALL NOT clear busy bits (in-flight long ops still complete).

Reset
REQ-026 rst_n low SHALL asynchronously clear busy to all-0 and pendingCount to 0.
REQ-027 With idle inputs during/after reset: stall_n=1, flushIdEx=0, flushIfIdExMem=0, hazardCause=NONE.
REQ-028 Reset mid-operation SHALL discard all pending entries; later wbValid for them SHALL be ignored per REQ-021.

Structure
REQ-029 RF_ADDR_WIDTH SHALL come from rv32i_defs; hazard_cause_t enum (NONE=0, BRANCH=1, LOAD_USE=2, RAW_LONG=3, WAW_LONG=4, FULL=5) SHALL live in shared package hdu_pkg.
REQ-030 Busy bitmap and counter SHALL be a sub-module hdu_scoreboard (set/clear ports, busyEff output, pendingCount); priority logic in top.

Verification
REQ-031 Load x5 in EX, ID add uses rs1=x5 -> stall_n=0, flushIdEx=1, cause=LOAD_USE; same with store rs2=x5 -> no stall.
REQ-032 Issue mul x7; next ID uses x7 -> stall each cycle until wbValid wbRd=7; that cycle stall_n=1 (bypass), pendingCount 1->0.
REQ-033 MAX_PENDING=2: issue to x1,x2; third long op to x3 -> cause=FULL; wbValid x1 same cycle -> issue proceeds, count stays 2.
REQ-034 branchOrJump with RAW hazard present -> 3'b111 outputs, cause=BRANCH, busy unchanged, no issue.
REQ-035 Long op rd=x0 -> no busy set, count 0; WAW to busy x9 -> cause=WAW_LONG.
REQ-036 rst_n low with count=3 -> busy all 0, count 0 immediately (asynchronous); stale wbValid x4 later ignored.
